// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - sequencing controller for the single-MAC 1-D convolution datapath
// Loads LENX samples, walks X/filter addresses per output, and hands each result downstream.
module conv_seq_ctrl #(
  parameter int LENX  = 8,
  parameter int LENF  = 4,
  parameter int ADDRX = $clog2(LENX),
  parameter int ADDRF = (LENF > 1) ? $clog2(LENF) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic             x_wr_en,
  output logic [ADDRX-1:0] x_addr,
  output logic [ADDRF-1:0] f_addr,
  output logic             mac_en,
  output logic             mac_first,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             y_last
);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUTPUT} state_t;

  localparam int SW = ADDRX + 1;
  localparam logic [ADDRX-1:0] WLAST = ADDRX'(LENX - 1);
  localparam logic [ADDRX-1:0] JLAST = ADDRX'(LENX - LENF);
  localparam logic [ADDRF-1:0] KLAST = ADDRF'(LENF - 1);

  state_t           state;
  logic [ADDRX-1:0] wcnt;
  logic [ADDRX-1:0] j;
  logic [ADDRF-1:0] k;
  logic             mac_en_q;
  logic             mac_first_q;
  logic [SW-1:0]    xsum;

  // One spare bit so an out-of-range tap address is visible instead of silently wrapping.
  assign xsum = SW'(j) + SW'(k);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      wcnt        <= '0;
      j           <= '0;
      k           <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
    end else begin
      // The memories return data one cycle after the address, so MAC controls trail by one.
      mac_en_q    <= (state == COMPUTE);
      mac_first_q <= (state == COMPUTE) && (k == '0);
      case (state)
        LOAD: begin
          if (s_valid_x) begin
            if (wcnt == WLAST) begin
              state <= COMPUTE;
              wcnt  <= '0;
              j     <= '0;
              k     <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (k == KLAST) begin
            state <= DRAIN;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: state <= OUTPUT;
        OUTPUT: begin
          if (m_ready_y) begin
            if (j == JLAST) begin
              state <= LOAD;
              j     <= '0;
            end else begin
              j     <= j + 1'b1;
              state <= COMPUTE;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_comb begin
    s_ready_x = 1'b0;
    x_wr_en   = 1'b0;
    x_addr    = '0;
    f_addr    = '0;
    m_valid_y = 1'b0;
    y_last    = 1'b0;
    if (!reset) begin
      case (state)
        LOAD: begin
          s_ready_x = 1'b1;
          x_wr_en   = s_valid_x;
          x_addr    = wcnt;
        end
        COMPUTE: begin
          x_addr = xsum[ADDRX-1:0];
          f_addr = k;
        end
        DRAIN: x_addr = j;
        OUTPUT: begin
          m_valid_y = 1'b1;
          y_last    = (j == JLAST);
          x_addr    = j;
        end
        default: x_addr = '0;
      endcase
    end
  end

  assign mac_en    = mac_en_q & ~reset;
  assign mac_first = mac_first_q & ~reset;

  a_no_addr_wrap: assert property (@(posedge clk) disable iff (reset)
    (state == COMPUTE) |-> (xsum < SW'(LENX)));

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - directed bench for conv_seq_ctrl (LENX=8/LENF=4 and LENX=LENF=4)
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_conv_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, s_valid_x, s_ready_x, x_wr_en, mac_en, mac_first, m_valid_y, m_ready_y, y_last;
  logic [2:0] x_addr;
  logic [1:0] f_addr;

  logic       b_reset, b_s_valid_x, b_s_ready_x, b_x_wr_en, b_mac_en, b_mac_first;
  logic       b_m_valid_y, b_m_ready_y, b_y_last;
  logic [1:0] b_x_addr;
  logic [1:0] b_f_addr;

  int total = 0;
  int bad = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl #(.LENX(8), .LENF(4)) dut (
    .clk(clk), .reset(reset), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .x_wr_en(x_wr_en), .x_addr(x_addr), .f_addr(f_addr), .mac_en(mac_en),
    .mac_first(mac_first), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y), .y_last(y_last)
  );

  conv_seq_ctrl #(.LENX(4), .LENF(4)) dut_b (
    .clk(clk), .reset(b_reset), .s_valid_x(b_s_valid_x), .s_ready_x(b_s_ready_x),
    .x_wr_en(b_x_wr_en), .x_addr(b_x_addr), .f_addr(b_f_addr), .mac_en(b_mac_en),
    .mac_first(b_mac_first), .m_valid_y(b_m_valid_y), .m_ready_y(b_m_ready_y), .y_last(b_y_last)
  );

  always @(posedge clk) if (x_wr_en === 1'b1) wr_count <= wr_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at the falling edge of COMPUTE cycle 1 for output jj; returns one cycle after the handshake.
  task automatic do_output(input int jj, input int stall);
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("cmp_s_ready", s_ready_x, 0);
      chk("cmp_wr_en", x_wr_en, 0);
      chk("cmp_m_valid", m_valid_y, 0);
      chk("cmp_mac_en", mac_en, (c >= 2));
      chk("cmp_mac_first", mac_first, (c == 2));
      chk("cmp_x_addr", x_addr, (c <= 4) ? jj + c - 1 : jj);
      chk("cmp_f_addr", f_addr, (c <= 4) ? c - 1 : 0);
      @(negedge clk);
    end
    for (int s = 0; s <= stall; s++) begin
      m_ready_y = (s == stall);
      #1;
      chk("out_m_valid", m_valid_y, 1);
      chk("out_y_last", y_last, (jj == 4));
      chk("out_mac_en", mac_en, 0);
      chk("out_mac_first", mac_first, 0);
      chk("out_x_addr", x_addr, jj);
      chk("out_f_addr", f_addr, 0);
      chk("out_wr_en", x_wr_en, 0);
      @(negedge clk);
    end
  endtask

  task automatic load_full();
    s_valid_x = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("ld_s_ready", s_ready_x, 1);
      chk("ld_wr_en", x_wr_en, 1);
      chk("ld_x_addr", x_addr, i);
      chk("ld_m_valid", m_valid_y, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int acc;
    int cyc;
    int wr_base;
    reset = 1'b1; s_valid_x = 1'b1; m_ready_y = 1'b1;
    b_reset = 1'b1; b_s_valid_x = 1'b0; b_m_ready_y = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready_x, 0);
    chk("rst_wr_en", x_wr_en, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_m_valid", m_valid_y, 0);
    chk("rst_y_last", y_last, 0);
    chk("rst_x_addr", x_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    // Frame 1: s_valid_x held high throughout, m_ready_y held high.
    load_full();
    for (int jj = 0; jj < 5; jj++) do_output(jj, 0);

    // Frame 2: random valid during load, stall on output j=1.
    wr_base = wr_count;
    acc = 0;
    cyc = 0;
    while (acc < 8 && cyc < 200) begin
      s_valid_x = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_s_ready", s_ready_x, 1);
      chk("rnd_wr_en", x_wr_en, s_valid_x);
      if (s_valid_x) begin
        chk("rnd_x_addr", x_addr, acc);
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rnd_accepts", acc, 8);
    s_valid_x = 1'b1;
    do_output(0, 0);
    do_output(1, 10);
    for (int jj = 2; jj < 5; jj++) do_output(jj, 0);
    chk("frame2_writes", wr_count - wr_base, 8);

    // Frame 3: reset during COMPUTE of output j=2.
    load_full();
    do_output(0, 0);
    do_output(1, 0);
    #1;
    chk("pre_rst_x_addr", x_addr, 2);
    @(negedge clk);
    reset = 1'b1;
    s_valid_x = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready_x, 0);
    chk("mid_rst_mac_en", mac_en, 0);
    chk("mid_rst_mac_first", mac_first, 0);
    chk("mid_rst_x_addr", x_addr, 0);
    chk("mid_rst_f_addr", f_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready_x, 1);
    chk("post_rst_m_valid", m_valid_y, 0);
    chk("post_rst_mac_en", mac_en, 0);
    chk("post_rst_x_addr", x_addr, 0);
    @(negedge clk);

    // Frame 4: clean frame after the mid-compute reset.
    load_full();
    for (int jj = 0; jj < 5; jj++) do_output(jj, 0);

    // LENX = LENF = 4: a single output.
    b_reset = 1'b0;
    b_s_valid_x = 1'b1;
    b_m_ready_y = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b_ld_s_ready", b_s_ready_x, 1);
      chk("b_ld_x_addr", b_x_addr, i);
      @(negedge clk);
    end
    b_s_valid_x = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("b_cmp_m_valid", b_m_valid_y, 0);
      chk("b_cmp_s_ready", b_s_ready_x, 0);
      chk("b_cmp_mac_en", b_mac_en, (c >= 2));
      if (c <= 4) begin
        chk("b_cmp_x_addr", b_x_addr, c - 1);
        chk("b_cmp_f_addr", b_f_addr, c - 1);
      end
      @(negedge clk);
    end
    #1;
    chk("b_out_m_valid", b_m_valid_y, 1);
    chk("b_out_y_last", b_y_last, 1);
    @(negedge clk);
    #1;
    chk("b_after_s_ready", b_s_ready_x, 1);
    chk("b_after_m_valid", b_m_valid_y, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
